// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid buffer for a pipeline control word.
// The head register feeds the output directly and the tail register absorbs
// one extra word when downstream stalls. Because every output is decoded
// from registered state, there is no combinational path from input to output.
// A saturating counter records the output cycles that stall.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               accept_s;
    logic               deliver_s;

    // Decode the handshake and the occupancy from registered state only.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        out_data  = head_q;
        stall_cnt = stall_q;
        accept_s  = in_valid && (state_q != FULL);
        deliver_s = out_out_ok(state_q, out_ready);
        case (state_q)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // A word leaves the stage whenever one is held and downstream is ready.
    function automatic logic out_out_ok(input state_e st, input logic rdy);
        return (st != EMPTY) && rdy;
    endfunction

    // Next state and register loads; flush overrides every transition and
    // discards the offered word, leaving head and tail untouched.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        head_d  = in_data;
                        state_d = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && deliver_s) begin
                        head_d  = in_data;
                        state_d = ONE;
                    end else if (accept_s) begin
                        tail_d  = in_data;
                        state_d = FULL;
                    end else if (deliver_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                FULL: begin
                    if (deliver_s) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Stall counter: count stalled output cycles (flush cycles included) and stick at the maximum.
    always_comb begin
        if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State, data and counter registers; reset empties the stage and clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= {WIDTH{1'b0}};
            tail_q  <= {WIDTH{1'b0}};
            stall_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for the two-entry skid buffer.
// Stimulus tracks an abstract model (a word count and a running stall total)
// and pushes every accepted word into a queue. A monitor compares the DUT
// against that model at each falling edge. A second instance with a 4-bit
// counter sees the same inputs, so the bench can check saturation.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [1:0]  occupancy4;
    logic [3:0]  stall_cnt4;

    int          checks = 0;
    int          errors = 0;
    int          model_occ = 0;
    int unsigned model_stall = 0;
    logic [31:0] sb_q[$];

    pipe_stage_reg #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
        .out_ready(out_ready), .occupancy(occupancy4), .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned m);
        return (v > m) ? m : v;
    endfunction

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        bit acc, del;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        acc = v && (model_occ < 2);
        del = r && (model_occ > 0);
        if (acc && !f) sb_q.push_back(d);
        @(posedge clk);
        #1;
        if (model_occ > 0 && !r) model_stall++;
        if (f) model_occ = 0;
        else   model_occ = model_occ + int'(acc) - int'(del);
    endtask

    // Monitor: compare status against the model, check the head word, retire deliveries.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("occupancy", 32'(occupancy), 32'(model_occ));
                chk("out_valid", 32'(out_valid), 32'(model_occ != 0));
                chk("in_ready", 32'(in_ready), 32'(model_occ != 2));
                chk("stall_cnt", 32'(stall_cnt), sat(model_stall, 32'd65535));
                chk("stall_cnt4", 32'(stall_cnt4), sat(model_stall, 32'd15));
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_word", out_data, 32'hDEAD_BEEF ^ out_data ^ 32'h1);
                    end else begin
                        chk("out_data", out_data, sb_q[0]);
                        if (out_ready) void'(sb_q.pop_front());
                    end
                end
                if (flush) sb_q.delete();
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Streaming: one word per cycle, occupancy stays at one.
        cycle(1'b1, 32'h11, 1'b1, 1'b0);
        cycle(1'b1, 32'h22, 1'b1, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: A and B fill the stage, C is held off, then drain.
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_stall_total", 32'(stall_cnt), 32'd3);

        // Flush in FULL with 7 offered: the stage empties and 7 is discarded.
        cycle(1'b1, 32'h5, 1'b0, 1'b0);
        cycle(1'b1, 32'h6, 1'b0, 1'b0);
        cycle(1'b1, 32'h7, 1'b0, 1'b1);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Saturation: hold one word stalled for 20 cycles.
        cycle(1'b1, 32'h99, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("sat4_value", 32'(stall_cnt4), 32'd15);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("sat4_hold", 32'(stall_cnt4), 32'd15);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while FULL, asserted between clock edges.
        cycle(1'b1, 32'h51, 1'b0, 1'b0);
        cycle(1'b1, 32'h52, 1'b0, 1'b0);
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        model_occ = 0; model_stall = 0; sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b1, 32'h61, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 49) == 0));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, giving the bit width of the carried pipeline control word.
REQ-002 The block SHALL take parameter CNT_W, default 16, giving the width of the stall-cycle counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, on the ports listed in REQ-004 and REQ-005.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port flush  input  1  discards all held words; next cycle the stage is empty.
REQ-007 Port in_valid  input  1  upstream word present.
REQ-008 Port in_data  input  WIDTH  upstream control word.
REQ-009 Port in_ready  output  1  stage can accept a word this cycle.
REQ-010 Port out_valid  output  1  head word present.
REQ-011 Port out_data  output  WIDTH  head control word.
REQ-012 Port out_ready  input  1  downstream accepts the head this cycle.
REQ-013 Port occupancy  output  2  number of held words, 0 to 2.
REQ-014 Port stall_cnt  output  CNT_W  count of stalled output cycles.

Function
REQ-015 The block SHALL be a 2-entry skid buffer with a head register and a tail register.
REQ-016 The block SHALL have three states: EMPTY (occupancy 0), ONE (occupancy 1) and FULL (occupancy 2).
REQ-017 Handshake terms:
- A word is accepted when in_valid && in_ready at a rising clk edge.
- A word is delivered when out_valid && out_ready at a rising clk edge.
REQ-018 Output decode SHALL be driven only from state, with no combinational in-to-out path:
- in_ready = (state != FULL).
- out_valid = (state != EMPTY).
- out_data = head register.
REQ-019 Latency SHALL be 1 cycle: a word accepted at edge N SHALL appear on out_data with out_valid=1 after edge N when the stage was EMPTY.
REQ-020 In EMPTY:
- Accept: head <= in_data, go to ONE.
- Otherwise: stay in EMPTY.
REQ-021 In ONE:
- Accept and deliver: head <= in_data, stay in ONE.
- Accept only: tail <= in_data, go to FULL.
- Deliver only: go to EMPTY.
- Neither: hold.
REQ-022 In FULL:
- Deliver: head <= tail, go to ONE.
- Otherwise: hold; no word is accepted because in_ready=0.
REQ-023 Words SHALL be delivered in strict acceptance order; none SHALL be duplicated or dropped except by flush or rst.
REQ-024 A held word's head/tail value SHALL NOT change while that word is not delivered.
REQ-025 Flush SHALL have priority over all other events:
- Next state is EMPTY regardless of in_valid or out_ready.
- A word offered during the flush cycle is discarded.
- out_valid and out_data in the flush cycle SHALL still reflect the pre-flush state; a delivery in that cycle is a legal transfer.
REQ-026 stall_cnt SHALL increment by 1 on each edge where out_valid && !out_ready, including flush cycles.
REQ-027 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 stall_cnt SHALL be cleared only by rst; flush SHALL NOT clear it.
REQ-029 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL respectively; the value 3 SHALL never occur.
REQ-030 Head and tail registers SHALL load only on the transitions listed in REQ-020 to REQ-022.

Reset
REQ-031 While rst=1, and immediately on its assertion without waiting for clk, the block SHALL drive:
- state = EMPTY, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
- out_data = 0; head and tail = 0.
REQ-032 Reset asserted mid-operation, including in FULL, SHALL discard all held words.
REQ-033 The first accepted word after rst deasserts SHALL be the first one delivered.

Verification
REQ-034 Streaming check:
- Stimulus: in_valid=1 with data 0x11, 0x22, 0x33 on consecutive cycles, out_ready=1 throughout.
- Response: out_data shows 0x11, 0x22, 0x33 on consecutive cycles, one cycle behind the input; occupancy stays 1; stall_cnt stays 0.
REQ-035 Backpressure check:
- Stimulus: out_ready=0; offer 0xA then 0xB.
- Response: occupancy becomes 2; in_ready=0; 0xC is held off.
- Then raise out_ready: outputs 0xA, then 0xB, then 0xC in order; stall_cnt equals the number of stalled cycles.
REQ-036 Flush-in-FULL check:
- Stimulus: stage FULL with 0x5, 0x6; flush=1 with in_valid=1 and in_data=0x7.
- Response: next cycle occupancy=0 and out_valid=0; 0x7 never appears.
REQ-037 Saturation check:
- Stimulus: CNT_W=4; hold out_valid=1 and out_ready=0 for 20 cycles.
- Response: stall_cnt reads 15 and stays at 15.
REQ-038 Asynchronous reset check:
- Stimulus: assert rst between clock edges while the stage is FULL.
- Response: out_valid=0, in_ready=1, occupancy=0, stall_cnt=0 before the next edge.
REQ-039 Random check:
- Stimulus: random in_valid, out_ready and flush for 10k cycles.
- Response: a scoreboard confirms in-order delivery without loss except at flushes, and occupancy never reaches 3.
